// File: rtl/link_pkg.sv
// Shared serial-beat layout and helpers for the credit-based internode link.
// LINK_PARITY_EN adds one even-parity bit on top of the credit/valid/flit beat.
package link_pkg;

   localparam int unsigned LINK_FLIT_W    = 128;
   localparam int unsigned VALID_BIT_OFS  = 0;
   localparam int unsigned CREDIT_BIT_OFS = 1;
   localparam int unsigned PARITY_BIT_OFS = 2;
   localparam int unsigned PARITY_MAX_W   = 1024;

`ifdef LINK_PARITY_EN
   localparam int unsigned SER_OVH = 3;
`else
   localparam int unsigned SER_OVH = 2;
`endif

   typedef struct packed {
      logic                   credit;
      logic                   valid;
      logic [LINK_FLIT_W-1:0] flit;
   } ser_beat_t;

   // Callers zero-extend their operand; zero padding leaves the parity unchanged.
   function automatic logic even_parity(input logic [PARITY_MAX_W-1:0] bits);
      return ^bits;
   endfunction

endpackage

// File: rtl/link_rx_fifo.sv
// First-word-fall-through synchronous FIFO with a sticky overflow flag.
// Push while full is accepted only if a pop frees a slot in the same cycle.
module link_rx_fifo #(
   parameter int unsigned DEPTH = 16,
   parameter int unsigned WIDTH = 128
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             push,
   input  logic [WIDTH-1:0] wdata,
   input  logic             pop,
   output logic [WIDTH-1:0] rdata,
   output logic             full,
   output logic             empty,
   output logic             overflow
);

   localparam int unsigned AW = $clog2(DEPTH);
   localparam logic [AW:0] PTR_ONE = {{AW{1'b0}}, 1'b1};

   logic [WIDTH-1:0] mem_q [DEPTH];
   logic [AW:0]      wr_ptr_q, rd_ptr_q;
   logic             overflow_q;
   logic             do_push, do_pop;

   // Extra pointer MSB tells a full FIFO from an empty one.
   assign empty    = (wr_ptr_q == rd_ptr_q);
   assign full     = (wr_ptr_q[AW] != rd_ptr_q[AW]) && (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
   assign do_pop   = pop && !empty;
   assign do_push  = push && (!full || do_pop);
   assign rdata    = empty ? '0 : mem_q[rd_ptr_q[AW-1:0]];
   assign overflow = overflow_q;

   always_ff @(posedge clk) begin
      if (do_push) begin
         mem_q[wr_ptr_q[AW-1:0]] <= wdata;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         wr_ptr_q   <= '0;
         rd_ptr_q   <= '0;
         overflow_q <= 1'b0;
      end else begin
         if (do_push) wr_ptr_q <= wr_ptr_q + PTR_ONE;
         if (do_pop)  rd_ptr_q <= rd_ptr_q + PTR_ONE;
         if (push && !do_push) overflow_q <= 1'b1;
      end
   end

endmodule

// File: rtl/credit_internode_link.sv
// One direction pair of a torus internode link: credit-gated TX delay line and RX FIFO.
// Define LINK_PARITY_EN for per-beat even parity and the parity_err_cnt port.
module credit_internode_link
   import link_pkg::*;
#(
   parameter int unsigned FLIT_W   = 128,
   parameter int unsigned DELAY    = 4,
   parameter int unsigned RX_DEPTH = 16,
   parameter int unsigned CNT_W    = $clog2(RX_DEPTH + 1)
) (
   input  logic                      clk,
   input  logic                      rst,
   input  logic [FLIT_W-1:0]         tx_par_data,
   input  logic                      tx_par_data_valid,
   output logic                      tx_ready,
   output logic [FLIT_W+SER_OVH-1:0] tx_ser_data,
   input  logic [FLIT_W+SER_OVH-1:0] rx_ser_data,
   output logic [FLIT_W-1:0]         rx_par_data,
   output logic                      rx_par_data_valid,
   input  logic                      rx_par_data_ready,
   output logic [CNT_W-1:0]          credit_count,
`ifdef LINK_PARITY_EN
   output logic [15:0]               parity_err_cnt,
`endif
   output logic                      overflow_err
);

   localparam int unsigned SER_W = FLIT_W + SER_OVH;
   localparam logic [CNT_W-1:0] FULL_CREDITS = CNT_W'(RX_DEPTH);
   localparam logic [CNT_W-1:0] CNT_ONE      = CNT_W'(1);

   logic             fire;
   logic             credit_in;
   logic             credit_out;
   logic             pop_fire;
   logic             rx_push;
   logic             rx_empty;
   logic             rx_full_unused;
   logic [FLIT_W-1:0] tx_flit;
   logic [SER_W-1:0] beat0;
   logic [SER_W-1:0] pipe_q [DELAY];
   logic [CNT_W-1:0] cnt_q, cnt_d;

   assign tx_ready     = (cnt_q != '0);
   assign fire         = tx_par_data_valid && tx_ready;
   assign credit_count = cnt_q;
   assign credit_in    = rx_ser_data[FLIT_W+CREDIT_BIT_OFS];
   assign pop_fire     = rx_par_data_valid && rx_par_data_ready;
   assign tx_flit      = fire ? tx_par_data : '0;

`ifdef LINK_PARITY_EN
   logic             rx_par_ok;
   logic             perr;
   logic [CNT_W-1:0] owed_q, owed_d;
   logic [15:0]      perr_cnt_q;

   assign rx_par_ok = rx_ser_data[FLIT_W+PARITY_BIT_OFS]
                      == even_parity(PARITY_MAX_W'(rx_ser_data[FLIT_W:0]));
   assign rx_push   = rx_ser_data[FLIT_W+VALID_BIT_OFS] && rx_par_ok;
   assign perr      = rx_ser_data[FLIT_W+VALID_BIT_OFS] && !rx_par_ok;
   // Only one credit fits in a beat; surplus credits queue up in owed_q.
   assign credit_out     = pop_fire || perr || (owed_q != '0);
   assign parity_err_cnt = perr_cnt_q;

   always_comb begin
      owed_d = owed_q;
      if (pop_fire && perr) begin
         owed_d = owed_q + CNT_ONE;
      end else if (!pop_fire && !perr && owed_q != '0) begin
         owed_d = owed_q - CNT_ONE;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         owed_q     <= '0;
         perr_cnt_q <= '0;
      end else begin
         owed_q <= owed_d;
         if (perr && perr_cnt_q != 16'hFFFF) perr_cnt_q <= perr_cnt_q + 16'd1;
      end
   end
`else
   assign rx_push    = rx_ser_data[FLIT_W+VALID_BIT_OFS];
   assign credit_out = pop_fire;
`endif

   always_comb begin
      beat0 = '0;
      beat0[FLIT_W-1:0]             = tx_flit;
      beat0[FLIT_W+VALID_BIT_OFS]   = fire;
      beat0[FLIT_W+CREDIT_BIT_OFS]  = credit_out;
`ifdef LINK_PARITY_EN
      beat0[FLIT_W+PARITY_BIT_OFS]  = even_parity(PARITY_MAX_W'({fire, tx_flit}));
`endif
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         for (int i = 0; i < DELAY; i++) pipe_q[i] <= '0;
      end else begin
         pipe_q[0] <= beat0;
         for (int i = 1; i < DELAY; i++) pipe_q[i] <= pipe_q[i-1];
      end
   end

   assign tx_ser_data = pipe_q[DELAY-1];

   // A credit arriving at the full count is dropped rather than wrapping.
   always_comb begin
      cnt_d = cnt_q;
      if (fire && !credit_in) begin
         cnt_d = cnt_q - CNT_ONE;
      end else if (!fire && credit_in && cnt_q != FULL_CREDITS) begin
         cnt_d = cnt_q + CNT_ONE;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) cnt_q <= FULL_CREDITS;
      else     cnt_q <= cnt_d;
   end

   link_rx_fifo #(
      .DEPTH (RX_DEPTH),
      .WIDTH (FLIT_W)
   ) u_rx_fifo (
      .clk      (clk),
      .rst      (rst),
      .push     (rx_push),
      .wdata    (rx_ser_data[FLIT_W-1:0]),
      .pop      (pop_fire),
      .rdata    (rx_par_data),
      .full     (rx_full_unused),
      .empty    (rx_empty),
      .overflow (overflow_err)
   );

   assign rx_par_data_valid = !rx_empty;

endmodule

// File: tb/tb_credit_internode_link.sv
// Loopback bench for credit_internode_link with a flit scoreboard and beat injection.
module tb_credit_internode_link;
   import link_pkg::*;

   localparam int unsigned FLIT_W   = 128;
   localparam int unsigned DELAY    = 4;
   localparam int unsigned RX_DEPTH = 16;
   localparam int unsigned CNT_W    = $clog2(RX_DEPTH + 1);
   localparam int unsigned SER_W    = FLIT_W + SER_OVH;

   logic              clk;
   logic              rst;
   logic [FLIT_W-1:0] tx_par_data;
   logic              tx_par_data_valid;
   logic              tx_ready;
   logic [SER_W-1:0]  tx_ser_data;
   logic [SER_W-1:0]  rx_ser_data;
   logic [FLIT_W-1:0] rx_par_data;
   logic              rx_par_data_valid;
   logic              rx_par_data_ready;
   logic [CNT_W-1:0]  credit_count;
   logic              overflow_err;
`ifdef LINK_PARITY_EN
   logic [15:0]       parity_err_cnt;
`endif

   logic              inject_en   = 1'b0;
   logic              corrupt_en  = 1'b0;
   logic              rand_ready  = 1'b0;
   logic [SER_W-1:0]  inject_beat = '0;
   logic [SER_W-1:0]  corrupt_mask;

   int n_checks = 0;
   int n_fail   = 0;
   logic [FLIT_W-1:0] exp_q [$];

   assign corrupt_mask = corrupt_en ? SER_W'(8) : '0;
   assign rx_ser_data  = inject_en ? inject_beat : (tx_ser_data ^ corrupt_mask);

   credit_internode_link #(
      .FLIT_W   (FLIT_W),
      .DELAY    (DELAY),
      .RX_DEPTH (RX_DEPTH),
      .CNT_W    (CNT_W)
   ) dut (
      .clk               (clk),
      .rst               (rst),
      .tx_par_data       (tx_par_data),
      .tx_par_data_valid (tx_par_data_valid),
      .tx_ready          (tx_ready),
      .tx_ser_data       (tx_ser_data),
      .rx_ser_data       (rx_ser_data),
      .rx_par_data       (rx_par_data),
      .rx_par_data_valid (rx_par_data_valid),
      .rx_par_data_ready (rx_par_data_ready),
      .credit_count      (credit_count),
`ifdef LINK_PARITY_EN
      .parity_err_cnt    (parity_err_cnt),
`endif
      .overflow_err      (overflow_err)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [255:0] got, input logic [255:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
      if (rand_ready) rx_par_data_ready = 1'($urandom_range(0, 1));
   endtask

   function automatic logic [FLIT_W-1:0] rand_flit();
      logic [FLIT_W-1:0] r;
      for (int i = 0; i < FLIT_W / 32; i++) r[i*32 +: 32] = $urandom;
      return r;
   endfunction

   task automatic send(input logic [FLIT_W-1:0] d);
      int t = 0;
      tx_par_data       = d;
      tx_par_data_valid = 1'b1;
      while (!tx_ready && t < 200) begin
         step();
         t++;
      end
      if (t >= 200) check("send_timeout", 256'(t), 256'(0));
      step();
      tx_par_data_valid = 1'b0;
   endtask

   task automatic drain(input string tag);
      rx_par_data_ready = 1'b1;
      for (int i = 0; i < 200 && !(exp_q.size() == 0 && credit_count == CNT_W'(RX_DEPTH)); i++)
         step();
      check({tag, "_sb_empty"}, 256'(exp_q.size()), 256'(0));
      check({tag, "_credits"}, 256'(credit_count), 256'(RX_DEPTH));
   endtask

   task automatic do_reset();
      rst = 1'b1;
      step();
      rst = 1'b0;
      exp_q.delete();
   endtask

   // Expected flits enter on TX fire and are compared when the consumer pops them.
   always @(negedge clk) begin
      if (!rst) begin
         if (tx_par_data_valid && tx_ready && !inject_en && !corrupt_en)
            exp_q.push_back(tx_par_data);
         if (rx_par_data_valid && rx_par_data_ready) begin
            if (exp_q.size() == 0) check("sb_unexpected_pop", 256'(exp_q.size()), 256'(1));
            else check("sb_data", 256'(rx_par_data), 256'(exp_q.pop_front()));
         end
      end
   end

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [FLIT_W-1:0] a5;
      int n;

      rst = 1'b1;
      tx_par_data = '0;
      tx_par_data_valid = 1'b0;
      rx_par_data_ready = 1'b0;
      step();
      step();
      rst = 1'b0;
      check("rst_credit", 256'(credit_count), 256'(RX_DEPTH));
      check("rst_tx_ready", 256'(tx_ready), 256'(1));
      check("rst_tx_ser", 256'(tx_ser_data), 256'(0));
      check("rst_rx_valid", 256'(rx_par_data_valid), 256'(0));
      check("rst_rx_data", 256'(rx_par_data), 256'(0));
      check("rst_overflow", 256'(overflow_err), 256'(0));

      // Single flit latency through the loopback.
      rx_par_data_ready = 1'b1;
      a5 = FLIT_W'(8'hA5);
      tx_par_data = a5;
      tx_par_data_valid = 1'b1;
      step();
      tx_par_data_valid = 1'b0;
      check("lat_credit_dec", 256'(credit_count), 256'(RX_DEPTH - 1));
      check("lat_rx_valid_early", 256'(rx_par_data_valid), 256'(0));
      repeat (DELAY - 1) step();
      check("lat_bus_valid", 256'(tx_ser_data[FLIT_W+VALID_BIT_OFS]), 256'(1));
      check("lat_bus_flit", 256'(tx_ser_data[FLIT_W-1:0]), 256'(a5));
`ifdef LINK_PARITY_EN
      check("lat_bus_parity", 256'(tx_ser_data[FLIT_W+PARITY_BIT_OFS]), 256'(^{1'b1, a5}));
`endif
      check("lat_rx_valid_still0", 256'(rx_par_data_valid), 256'(0));
      step();
      check("lat_rx_valid", 256'(rx_par_data_valid), 256'(1));
      check("lat_rx_data", 256'(rx_par_data), 256'(a5));
      drain("lat");

      // Random stream with a randomly stalling consumer.
      rand_ready = 1'b1;
      for (int k = 0; k < 12; k++) send(rand_flit());
      rand_ready = 1'b0;
      drain("stream");

      // Stalled consumer: only RX_DEPTH flits may be accepted.
      rx_par_data_ready = 1'b0;
      n = 0;
      for (int i = 0; i < 20; i++) begin
         tx_par_data = rand_flit();
         tx_par_data_valid = 1'b1;
         if (tx_ready) n++;
         step();
      end
      tx_par_data_valid = 1'b0;
      check("stall_accepted", 256'(n), 256'(RX_DEPTH));
      check("stall_tx_ready", 256'(tx_ready), 256'(0));
      check("stall_credit", 256'(credit_count), 256'(0));
      repeat (DELAY + 1) step();
      check("stall_overflow", 256'(overflow_err), 256'(0));
      check("stall_sb_depth", 256'(exp_q.size()), 256'(RX_DEPTH));

      // One pop returns exactly one credit DELAY cycles later.
      rx_par_data_ready = 1'b1;
      step();
      rx_par_data_ready = 1'b0;
      repeat (DELAY - 1) step();
      check("ret_bus_credit", 256'(tx_ser_data[FLIT_W+CREDIT_BIT_OFS]), 256'(1));
      check("ret_credit_before", 256'(credit_count), 256'(0));
      step();
      check("ret_credit_after", 256'(credit_count), 256'(1));
      check("ret_tx_ready", 256'(tx_ready), 256'(1));
      send(rand_flit());
      check("ret_17th_accepted", 256'(credit_count), 256'(0));
      repeat (DELAY + 1) step();
      check("ret_overflow", 256'(overflow_err), 256'(0));

      // Beat injected into a full FIFO is dropped and flagged.
      inject_en = 1'b1;
      inject_beat = '0;
      inject_beat[FLIT_W-1:0] = rand_flit();
      inject_beat[FLIT_W+VALID_BIT_OFS] = 1'b1;
`ifdef LINK_PARITY_EN
      inject_beat[FLIT_W+PARITY_BIT_OFS] = ^inject_beat[FLIT_W:0];
`endif
      step();
      inject_beat = '0;
      check("ovf_set", 256'(overflow_err), 256'(1));
      repeat (3) step();
      check("ovf_sticky", 256'(overflow_err), 256'(1));
      do_reset();
      check("rst2_credit", 256'(credit_count), 256'(RX_DEPTH));
      check("rst2_tx_ready", 256'(tx_ready), 256'(1));
      check("rst2_tx_ser", 256'(tx_ser_data), 256'(0));
      check("rst2_rx_valid", 256'(rx_par_data_valid), 256'(0));
      check("rst2_rx_data", 256'(rx_par_data), 256'(0));
      check("rst2_overflow", 256'(overflow_err), 256'(0));

      // Credit counter arithmetic with injected credit beats.
      inject_beat[FLIT_W+CREDIT_BIT_OFS] = 1'b1;
      step();
      inject_beat = '0;
      check("cnt_saturate", 256'(credit_count), 256'(RX_DEPTH));
      tx_par_data = rand_flit();
      tx_par_data_valid = 1'b1;
      repeat (RX_DEPTH - 5) step();
      tx_par_data_valid = 1'b0;
      check("cnt_at5", 256'(credit_count), 256'(5));
      inject_beat[FLIT_W+CREDIT_BIT_OFS] = 1'b1;
      tx_par_data_valid = 1'b1;
      step();
      tx_par_data_valid = 1'b0;
      check("cnt_fire_and_credit", 256'(credit_count), 256'(5));
      step();
      check("cnt_credit_only", 256'(credit_count), 256'(6));
      inject_beat = '0;
      tx_par_data_valid = 1'b1;
      step();
      tx_par_data_valid = 1'b0;
      check("cnt_fire_only", 256'(credit_count), 256'(5));
      inject_en = 1'b0;
      do_reset();

`ifdef LINK_PARITY_EN
      // Corrupted flit bit 3: no push, but the credit still comes home.
      check("par_cnt_reset", 256'(parity_err_cnt), 256'(0));
      corrupt_en = 1'b1;
      rx_par_data_ready = 1'b1;
      send(rand_flit());
      check("par_credit_dec", 256'(credit_count), 256'(RX_DEPTH - 1));
      for (int i = 0; i < 40 && credit_count != CNT_W'(RX_DEPTH); i++) step();
      check("par_credit_back", 256'(credit_count), 256'(RX_DEPTH));
      check("par_err_cnt", 256'(parity_err_cnt), 256'(1));
      check("par_no_push", 256'(rx_par_data_valid), 256'(0));
      corrupt_en = 1'b0;
`endif

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/credit_internode_link.md
Name: credit_internode_link

Overview:
Parametrised successor of the per-direction internode link model used in each torus node. It carries flits between neighbouring nodes over a serial bus with a configurable delay. The new parts are credit-based flow control, a receive FIFO with a ready/valid consumer handshake, and credit return piggybacked on the reverse serial bus. One instance sits between a router output/input pair and the neighbouring node.

Parameters:
FLIT_W, 128, flit payload width in bits
DELAY, 4, serial-bus pipeline stages in the TX direction (legal range >=1)
RX_DEPTH, 16, receive FIFO entries (power of 2, >=2); also the initial credit count
CNT_W, $clog2(RX_DEPTH+1), width of the credit counter

Ports:
clk  in  1  clock
rst  in  1  reset; synchronous, active-high
tx_par_data  in  FLIT_W  flit from router output
tx_par_data_valid  in  1  flit offered
tx_ready  out  1  credits available; transfer occurs when valid && ready
tx_ser_data  out  FLIT_W+2  serial bus to peer: [FLIT_W+1]=credit, [FLIT_W]=valid, [FLIT_W-1:0]=flit
rx_ser_data  in  FLIT_W+2  serial bus from peer, same layout
rx_par_data  out  FLIT_W  head flit of the RX FIFO
rx_par_data_valid  out  1  FIFO not empty
rx_par_data_ready  in  1  consumer pops when valid && ready
credit_count  out  CNT_W  current TX credits (debug)
overflow_err  out  1  sticky; set when a flit arrives while the FIFO is full and no pop occurs

Behaviour:
- Reset (synchronous, active-high):
  - credit_count=RX_DEPTH, tx_ready=1.
  - All DELAY stages cleared, so tx_ser_data=0.
  - FIFO empty, rx_par_data_valid=0, rx_par_data=0, overflow_err=0.
  - Reset mid-traffic discards in-flight flits and credits.
- TX accept: fire = tx_par_data_valid && tx_ready; tx_ready = (credit_count != 0).
- The flit plus valid bit enter stage 0 on the fire edge and appear on tx_ser_data after exactly DELAY cycles.
- Credit return: when an RX pop occurs in cycle t, the credit bit is set in the stage-0 entry of that same cycle. It travels with any flit in that stage; the credit field and the valid field are independent. At most one credit is returned per cycle.
- Credit counter:
  - Decrement on fire.
  - Increment when rx_ser_data[FLIT_W+1]=1.
  - Both in the same cycle: no net change.
  - Never exceeds RX_DEPTH; a credit arriving at RX_DEPTH is ignored (saturation).
  - Never underflows (guaranteed by tx_ready gating).
- RX push: rx_ser_data[FLIT_W]=1 writes the flit at the tail. Push to an empty FIFO makes the flit visible (valid=1) the next cycle, so latency is 1.
- RX pop: rx_par_data is first-word-fall-through. Pop advances the head; the next entry is visible the following cycle.
- Full boundary:
  - Push + pop in the same cycle when full: both succeed and the count is unchanged.
  - Push when full without pop: flit dropped, overflow_err=1 (sticky until rst), no credit returned.
- Pointers wrap modulo RX_DEPTH using one extra bit for full/empty discrimination.
- End-to-end: flit on tx_par_data at cycle t appears on the peer's rx_par_data_valid at t+DELAY+1.

Optional Feature:
LINK_PARITY_EN
- Defined:
  - The serial buses widen to FLIT_W+3; bit [FLIT_W+2] carries even parity over valid and flit.
  - RX checks parity on every valid beat. On mismatch the flit is not pushed, a credit is returned immediately on the next stage-0 entry, and output parity_err_cnt (16 bit, saturating, reset 0) increments.
- Undefined: buses are FLIT_W+2 wide, no parity_err_cnt port, no checking.

Decomposition:
- Package link_pkg:
  - Serial field index constants: CREDIT_BIT_OFS and VALID_BIT_OFS relative to FLIT_W, PARITY_BIT_OFS.
  - Typedef ser_beat_t as a packed struct {credit, valid, flit}, parametrised via FLIT_W from para.sv.
  - Function even_parity.
- One sub-module: link_rx_fifo (FWFT sync FIFO, DEPTH, WIDTH, push/pop/full/empty/overflow).
- TX delay line and credit counter stay in the top.

Test Plan:
- Loopback (tx_ser_data to own rx_ser_data), DELAY=4, RX_DEPTH=16: one flit 0xA5 at cycle 10 -> rx_par_data_valid=1 with 0xA5 at cycle 15; credit_count goes 16->15 at cycle 11.
- Consumer stalled (ready=0), source streams 20 flits -> exactly 16 accepted, tx_ready=0 after 16th, credit_count=0, overflow_err=0.
- From the stalled state, raise ready for one cycle -> one pop, credit bit seen DELAY cycles later on the bus, credit_count 0->1, tx_ready=1, 17th flit accepted.
- Credit arrival and fire in the same cycle at credit_count=5 -> stays 5.
- Inject a valid beat into rx_ser_data directly while the FIFO is full and ready=0 -> flit dropped, overflow_err=1 and held; then rst=1 for one cycle -> all outputs at reset values, credit_count=16.
- With LINK_PARITY_EN, flip flit bit 3 on the bus -> no push, parity_err_cnt=1, credit returned, credit_count recovers to 16.
